// File: rtl/edf_sched_pkg.sv
// edf_sched_pkg: slot states, default widths and the modular slack helper for the EDF scheduler
package edf_sched_pkg;
  localparam int DW_DEF = 6;
  localparam int DL_W_DEF = 6;
  typedef enum logic [1:0] {EMPTY, FETCH, HELD} slot_state_t;
  function automatic logic signed [31:0] slack(input logic [31:0] dl, input logic [31:0] t, input int unsigned w);
    logic [31:0] d;
    d = (dl - t) << (32 - w);
    return $signed(d) >>> (32 - w);
  endfunction
endpackage

// File: rtl/edf_head_slot.sv
// edf_head_slot: prefetches one FIFO head into a slot and releases it when the selector takes it
module edf_head_slot
  import edf_sched_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic          take,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          fifo_rd_en,
  output logic          held,
  output logic [DW-1:0] data
);
  slot_state_t st;
  assign held = st == HELD;
  assign fifo_rd_en = !rst && !fifo_empty && (st == EMPTY || (held && take));
  always_ff @(posedge clk)
    if (rst) begin
      st <= EMPTY;
      data <= '0;
    end else begin
      if (st == FETCH) data <= fifo_rd_data;
      st <= st == FETCH ? HELD : (st == EMPTY || take) ? (fifo_empty ? EMPTY : FETCH) : HELD;
    end
endmodule

// File: rtl/edf_fifo_scheduler.sv
// edf_fifo_scheduler: earliest-deadline-first read scheduler over NUM_Q FIFO heads; EDF_DROP_EXPIRED_EN drops expired heads
module edf_fifo_scheduler
  import edf_sched_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int DW    = DW_DEF,
  parameter int DL_W  = DL_W_DEF,
  parameter int QID_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_Q-1:0]    fifo_empty,
  output logic [NUM_Q-1:0]    fifo_rd_en,
  input  logic [NUM_Q*DW-1:0] fifo_rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [QID_W-1:0]    out_qid,
  output logic                out_expired,
`ifdef EDF_DROP_EXPIRED_EN
  output logic [15:0]         drop_cnt,
`endif
  output logic [DL_W-1:0]     now
);
  logic [NUM_Q-1:0] held, take, expired, cand, drop;
  logic [DW-1:0] head [NUM_Q];
  logic signed [31:0] sl [NUM_Q];
  logic signed [31:0] best;
  logic [QID_W-1:0] win;
  logic any, load;
  for (genvar g = 0; g < NUM_Q; g++) begin : g_slot
    edf_head_slot #(.DW(DW)) u_slot (
      .clk,
      .rst,
      .fifo_empty(fifo_empty[g]),
      .take(take[g]),
      .fifo_rd_data(fifo_rd_data[g*DW +: DW]),
      .fifo_rd_en(fifo_rd_en[g]),
      .held(held[g]),
      .data(head[g])
    );
  end
  always_comb
    for (int i = 0; i < NUM_Q; i++) begin
      sl[i] = slack(32'(head[i][DL_W-1:0]), 32'(now), DL_W);
      expired[i] = sl[i][31];
    end
`ifdef EDF_DROP_EXPIRED_EN
  logic [NUM_Q-1:0] xh;
  assign xh = held & expired;
  assign cand = held & ~expired;
  assign drop = xh & ~(xh - NUM_Q'(1));
`else
  assign cand = held;
  assign drop = '0;
`endif
  always_comb begin
    any = 1'b0;
    best = '0;
    win = '0;
    for (int i = 0; i < NUM_Q; i++)
      if (cand[i] && (!any || sl[i] < best)) begin
        any = 1'b1;
        best = sl[i];
        win = QID_W'(i);
      end
  end
  assign load = any && (!out_valid || out_ready);
  assign take = ({NUM_Q{load}} & (NUM_Q'(1) << win)) | drop;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_qid <= '0;
      out_expired <= 1'b0;
      now <= '0;
    end else begin
      now <= now + DL_W'(1);
      if (load) begin
        out_valid <= 1'b1;
        out_data <= head[win];
        out_qid <= win;
`ifdef EDF_DROP_EXPIRED_EN
        out_expired <= 1'b0;
`else
        out_expired <= expired[win];
`endif
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef EDF_DROP_EXPIRED_EN
  always_ff @(posedge clk)
    if (rst) drop_cnt <= '0;
    else if (|drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_edf_fifo_scheduler.sv
// tb_edf_fifo_scheduler: directed stimulus with FIFO models and a scoreboard monitor for edf_fifo_scheduler
module tb_edf_fifo_scheduler;
  localparam int NUM_Q = 4, DW = 6, DL_W = 6, QID_W = 2;
  logic clk = 0, rst = 1;
  logic [NUM_Q-1:0] fifo_empty = '1, fifo_rd_en;
  logic [NUM_Q*DW-1:0] fifo_rd_data = '0;
  logic out_valid, out_ready = 0, out_expired;
  logic [DW-1:0] out_data;
  logic [QID_W-1:0] out_qid;
  logic [DL_W-1:0] now;
`ifdef EDF_DROP_EXPIRED_EN
  logic [15:0] drop_cnt;
`endif
  typedef struct packed {
    logic [DW-1:0] d;
    logic [QID_W-1:0] q;
    logic e;
  } exp_t;
  exp_t sb[$];
  logic [DW-1:0] fq[NUM_Q][$];
  int rd_cnt[NUM_Q];
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  edf_fifo_scheduler #(.NUM_Q(NUM_Q), .DW(DW), .DL_W(DL_W), .QID_W(QID_W)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_qid(out_qid),
    .out_expired(out_expired),
`ifdef EDF_DROP_EXPIRED_EN
    .drop_cnt(drop_cnt),
`endif
    .now(now)
  );

  task automatic chk(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d want %0d", name, act, req);
  endtask

  task automatic upd();
    for (int i = 0; i < NUM_Q; i++) fifo_empty[i] = fq[i].size() == 0;
  endtask

  task automatic push(int q, int d);
    fq[q].push_back(DW'(d));
    upd();
  endtask

  task automatic expect_out(int d, int q, int e);
    sb.push_back('{d: DW'(d), q: QID_W'(q), e: 1'(e)});
  endtask

  task automatic cyc();
    logic [NUM_Q-1:0] en;
    @(negedge clk);
    en = fifo_rd_en;
    for (int i = 0; i < NUM_Q; i++) if (en[i]) chk("rd_on_empty", fifo_empty[i], 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_Q; i++)
      if (en[i]) begin
        rd_cnt[i]++;
        if (fq[i].size() > 0) fifo_rd_data[i*DW +: DW] = fq[i].pop_front();
      end
    upd();
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < NUM_Q; i++) rd_cnt[i] = 0;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got data %0d qid %0d, want none", out_data, out_qid);
        end else begin
          x = sb.pop_front();
          chk("out_data", out_data, x.d);
          chk("out_qid", out_qid, x.q);
          chk("out_expired", out_expired, x.e);
        end
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_qid", out_qid, 0);
    chk("rst_out_expired", out_expired, 0);
    chk("rst_now", now, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
`ifdef EDF_DROP_EXPIRED_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    // single queue, latency and no overread
    out_ready = 1;
    push(0, 5); push(0, 9);
    expect_out(5, 0, 0); expect_out(9, 0, 0);
    cyc(); cyc();
    chk("t1_latency_early", out_valid, 0);
    cyc();
    chk("t1_latency", out_valid, 1);
    repeat (6) cyc();
    chk("t1_rd_cnt", rd_cnt[0], 2);
    // EDF ordering with tie on lowest index
    do_reset();
    out_ready = 1;
    push(0, 20); push(1, 12); push(2, 30); push(3, 12);
    expect_out(12, 1, 0); expect_out(12, 3, 0); expect_out(20, 0, 0); expect_out(30, 2, 0);
    repeat (3) cyc();
    for (int k = 0; k < 4; k++) begin
      chk("t2_consecutive", out_valid, 1);
      cyc();
    end
    // wrap-around of now
    do_reset();
    for (int k = 0; k < 100 && now != 58; k++) cyc();
    chk("t3_wait_now", now, 58);
    push(0, 2); push(1, 62);
    expect_out(62, 1, 0); expect_out(2, 0, 0);
    repeat (6) cyc();
    // backpressure then full rate release
    do_reset();
    out_ready = 0;
    push(0, 28); push(0, 31); push(1, 27); push(1, 32);
    push(2, 29); push(2, 33); push(3, 26); push(3, 30);
    expect_out(26, 3, 0); expect_out(27, 1, 0); expect_out(28, 0, 0); expect_out(29, 2, 0);
    expect_out(30, 3, 0); expect_out(31, 0, 0); expect_out(32, 1, 0); expect_out(33, 2, 0);
    repeat (3) cyc();
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_data", out_data, 26);
      chk("t4_stall_qid", out_qid, 3);
      cyc();
    end
    chk("t4_rd_cnt0", rd_cnt[0], 1);
    chk("t4_rd_cnt1", rd_cnt[1], 1);
    chk("t4_rd_cnt2", rd_cnt[2], 1);
    chk("t4_rd_cnt3", rd_cnt[3], 2);
    out_ready = 1;
    cyc();
    for (int k = 0; k < 7; k++) begin
      chk("t4_rate", out_valid, 1);
      cyc();
    end
    // expired head
    do_reset();
    out_ready = 1;
    push(0, 63); push(1, 20);
`ifndef EDF_DROP_EXPIRED_EN
    expect_out(63, 0, 1);
`endif
    expect_out(20, 1, 0);
    repeat (6) cyc();
`ifdef EDF_DROP_EXPIRED_EN
    chk("t5_drop_cnt", drop_cnt, 1);
`endif
    // reset mid-stream
    do_reset();
    out_ready = 0;
    push(0, 10); push(0, 11); push(0, 14); push(1, 12); push(1, 13);
    repeat (4) cyc();
    chk("t6_pre_valid", out_valid, 1);
    rst = 1;
    push(2, 20);
    #1;
    chk("t6_rd_en_in_rst", fifo_rd_en, 0);
    cyc();
    rst = 0;
    chk("t6_post_valid", out_valid, 0);
    chk("t6_post_now", now, 0);
    out_ready = 1;
    expect_out(13, 1, 0); expect_out(14, 0, 0); expect_out(20, 2, 0);
    repeat (8) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
